// File: rtl/mem_dma_pkg.sv
// Shared constants and types for the image-memory burst engine.
package mem_dma_pkg;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 49152;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RD   = 2'd1;
  localparam state_t S_WR   = 2'd2;
  localparam state_t S_DONE = 2'd3;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  // One extra bit so base+length cannot wrap before the comparison.
  function automatic logic range_ok(input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] len);
    logic [ADDR_W:0] end_a;
    end_a = {1'b0, base} + {1'b0, len};
    return end_a <= (ADDR_W+1)'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/mem_dma_stream_fifo.sv
// Small synchronous FIFO with occupancy output; absorbs read-stream backpressure.
module stream_fifo
  import mem_dma_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     store_q [DEPTH];
  logic [PTR_W-1:0] wp_q, rp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign pop_data = store_q[rp_q];

  always_ff @(posedge clk) begin
    if (do_push) store_q[wp_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
      if (do_pop)  rp_q <= (rp_q == PTR_W'(DEPTH - 1)) ? '0 : rp_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mem_dma.sv
// Burst engine in front of the single-port image memory: streams consecutive
// words out (read burst) or writes an incoming stream to consecutive addresses.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, len_q;
  logic [ADDR_W-1:0] issue_cnt_q, xfer_cnt_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] wdata_hold_q;
  logic              err_q;
  logic              vld_p1;

  logic              cmd_zero, cmd_bad, accept;
  logic              issue_p0, pop, wr_hs, rd_last, wr_last;
  logic [OCC_W+1:0]  credit_use;
  logic              fifo_full, fifo_empty;
  logic [OCC_W-1:0]  fifo_occ;
  logic [DATA_W-1:0] fifo_head;

  assign accept   = (state_q == S_IDLE) && start;
  assign cmd_zero = (length == '0);
  assign cmd_bad  = !range_ok(base_addr, length);

  // Credit: words already buffered plus the one arriving from memory, minus the
  // one leaving now, must leave room for the word issued this cycle.
  assign credit_use = (OCC_W+2)'(fifo_occ) + (OCC_W+2)'(vld_p1) - (OCC_W+2)'(pop);
  assign issue_p0   = (state_q == S_RD) && (issue_cnt_q != len_q) &&
                      (credit_use < (OCC_W+2)'(FIFO_DEPTH));

  assign rd_valid = !fifo_empty;
  assign rd_data  = fifo_head;
  assign pop      = rd_valid && rd_ready;
  assign rd_last  = pop && (xfer_cnt_q == len_q - ADDR_W'(1));

  assign wr_ready = (state_q == S_WR);
  assign wr_hs    = wr_ready && wr_valid;
  assign wr_last  = wr_hs && (xfer_cnt_q == len_q - ADDR_W'(1));
  assign mem_we   = wr_hs && !rst;

  always_comb begin
    mem_address = addr_hold_q;
    if (issue_p0)               mem_address = base_q + issue_cnt_q;
    else if (state_q == S_WR)   mem_address = base_q + xfer_cnt_q;
  end

  assign mem_data_out = (state_q == S_WR) ? wr_data : wdata_hold_q;

  assign busy = (state_q == S_RD) || (state_q == S_WR);
  assign done = (state_q == S_DONE);
  assign err  = (state_q == S_DONE) && err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (cmd_zero || cmd_bad) state_d = S_DONE;
        else if (dir == DIR_WR)  state_d = S_WR;
        else                     state_d = S_RD;
      end
      S_RD:   if (rd_last) state_d = S_DONE;
      S_WR:   if (wr_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      issue_cnt_q  <= '0;
      xfer_cnt_q   <= '0;
      err_q        <= 1'b0;
      vld_p1       <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      vld_p1       <= issue_p0;
      addr_hold_q  <= mem_address;
      wdata_hold_q <= mem_data_out;
      if (accept) begin
        base_q      <= base_addr;
        len_q       <= length;
        issue_cnt_q <= '0;
        xfer_cnt_q  <= '0;
        err_q       <= !cmd_zero && cmd_bad;
      end else begin
        if (issue_p0)     issue_cnt_q <= issue_cnt_q + ADDR_W'(1);
        if (pop || wr_hs) xfer_cnt_q  <= xfer_cnt_q + ADDR_W'(1);
      end
    end
  end

  // Stage p1: memory returns the word issued last cycle; capture it.
  stream_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (mem_data_in),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_occ)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: behavioural image memory, command table, read scoreboard.
module tb_mem_dma;
  import mem_dma_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, dir;
  logic [ADDR_W-1:0] base_addr, length;
  logic              busy, done, err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_out, mem_data_in;
  logic              mem_we;
  logic [DATA_W-1:0] rd_data, wr_data;
  logic              rd_valid, rd_ready, wr_valid, wr_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_dma dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .err(err),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_we(mem_we),
    .mem_data_in(mem_data_in), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready)
  );

  function automatic logic [63:0] pat(input int a);
    return {16'hD00D, a[15:0], 32'(a * 32'h9E3779B9)};
  endfunction

  // Single-port memory with one-cycle registered read.
  logic [63:0] mem [MEM_DEPTH];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else if (mem_we && int'(mem_address) < MEM_DEPTH) begin
      mem[mem_address] <= mem_data_out;
    end
    mem_data_in <= (int'(mem_address) < MEM_DEPTH) ? mem[mem_address] : 64'h0;
  end

  logic [63:0] wr_shadow [int];
  logic [63:0] exp_q [$];

  function automatic logic [63:0] exp_word(input int a);
    return wr_shadow.exists(a) ? wr_shadow[a] : pat(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  typedef struct {
    logic        dir;
    int          base;
    int          len;
    int          mode;        // 0 always ready/valid, 1 toggling, 2 random
    logic [63:0] wd0;
    logic        exp_err;
    int          exp_done;    // cycle after start at which done is due, 0 = any
    int          exp_first;   // cycle of first rd_valid, 0 = unchecked
  } vec_t;

  task automatic run_cmd(input vec_t v);
    int cyc, k, got, wk, first;
    bit seen_done, legal, exp_wr;
    logic rr, wv;
    logic [63:0] e;
    legal = (v.len > 0) && (v.base + v.len <= MEM_DEPTH);
    exp_q.delete();
    if (!v.dir && legal)
      for (int i = 0; i < v.len; i++) exp_q.push_back(exp_word(v.base + i));
    @(posedge clk); #1;
    start = 1'b1; dir = v.dir; base_addr = ADDR_W'(v.base); length = ADDR_W'(v.len);
    rd_ready = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    cyc = 0; got = 0; wk = 0; first = 0; seen_done = 0;
    while (!seen_done && cyc < 400) begin
      k = cyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
      case (v.mode)
        0:       begin rr = 1'b1; wv = 1'b1; end
        1:       begin rr = k[0]; wv = k[0]; end
        default: begin rr = 1'($urandom_range(0, 1)); wv = 1'($urandom_range(0, 1)); end
      endcase
      rd_ready = v.dir ? 1'b0 : rr;
      wr_valid = v.dir ? wv : 1'b0;
      wr_data  = v.wd0 + 64'(wk);
      @(negedge clk);
      cyc = k;
      exp_wr = v.dir && legal && (wk < v.len);
      chk("wr_ready", wr_ready, exp_wr);
      chk("mem_we", mem_we, exp_wr && wr_valid);
      if (exp_wr && wr_valid) begin
        chk("wr_addr", mem_address, 64'(v.base + wk));
        chk("wr_data", mem_data_out, wr_data);
        wr_shadow[v.base + wk] = wr_data;
        wk++;
      end
      if (rd_valid && rd_ready) begin
        if (first == 0) first = cyc;
        got++;
        if (exp_q.size() == 0) chk("rd_extra", rd_data, 64'hx);
        else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
        end
      end
      if (done) seen_done = 1;
      chk("err", err, done && v.exp_err);
      chk("busy", busy, legal && !done);
      if (v.exp_done != 0) chk("done_cycle", done, cyc == v.exp_done);
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    if (v.exp_first != 0) chk("rd_latency", first, v.exp_first);
    chk("rd_words", got, (!v.dir && legal) ? v.len : 0);
    chk("wr_words", wk, (v.dir && legal) ? v.len : 0);
    chk("sb_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    rd_ready = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1'b0, 'h0010, 4, 0, 64'h0, 1'b0, 7, 3};
    vecs[1]  = '{1'b0, 'h0100, 8, 1, 64'h0, 1'b0, 0, 0};
    vecs[2]  = '{1'b1, 'hBFFD, 3, 0, 64'hA, 1'b0, 4, 0};
    vecs[3]  = '{1'b0, 'hBFFD, 3, 0, 64'h0, 1'b0, 6, 3};
    vecs[4]  = '{1'b0, 'hBFFF, 2, 0, 64'h0, 1'b1, 1, 0};
    vecs[5]  = '{1'b0, 'h0000, 0, 0, 64'h0, 1'b0, 1, 0};
    vecs[6]  = '{1'b1, 'h0200, 5, 2, 64'h1234_5678_9ABC_0000, 1'b0, 0, 0};
    vecs[7]  = '{1'b0, 'h0200, 5, 2, 64'h0, 1'b0, 0, 0};
    vecs[8]  = '{1'b1, 'hC000, 1, 0, 64'h55, 1'b1, 1, 0};
    vecs[9]  = '{1'b0, 'hBFFF, 1, 0, 64'h0, 1'b0, 4, 3};
    vecs[10] = '{1'b1, 'h0040, 4, 1, 64'hFEED_0000, 1'b0, 0, 0};
    vecs[11] = '{1'b0, 'h0040, 4, 0, 64'h0, 1'b0, 7, 3};

    rst = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; length = '0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;

    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("rst_mem_we", mem_we, 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_we2", mem_we, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data_out", mem_data_out, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);

    for (int i = 0; i < 12; i++) run_cmd(vecs[i]);

    // Reset in the middle of a 6-word read, after two words have been taken.
    begin
      int got, cyc;
      logic [63:0] e;
      exp_q.delete();
      for (int i = 0; i < 6; i++) exp_q.push_back(exp_word('h300 + i));
      @(posedge clk); #1;
      start = 1'b1; dir = 1'b0; base_addr = 16'h0300; length = 16'd6;
      @(negedge clk);
      got = 0; cyc = 0;
      while (got < 2 && cyc < 20) begin
        @(posedge clk); #1; start = 1'b0; rd_ready = 1'b1;
        @(negedge clk); cyc++;
        if (rd_valid && rd_ready) begin
          e = exp_q.pop_front();
          chk("mid_rd_data", rd_data, e);
          got++;
        end
      end
      chk("mid_got_two", got, 2);
      @(posedge clk); #1; rst = 1'b1; rd_ready = 1'b0;
      @(negedge clk);
      chk("mid_rst_mem_we", mem_we, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("mid_rd_valid", rd_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      chk("mid_err", err, 0);
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1; rd_ready = 1'b1;
        @(negedge clk);
        chk("mid_quiet_valid", rd_valid, 0);
        chk("mid_quiet_done", done, 0);
      end
      rd_ready = 1'b0;
    end
    run_cmd('{1'b0, 'h0400, 1, 0, 64'h0, 1'b0, 4, 3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Burst-transfer engine sitting directly in front of the 64-bit image memory (single port, 1-cycle registered read, 49152 words). It owns that memory's address, data and write-enable inputs. On a start command it either streams a run of consecutive words out of memory over a valid/ready stream (read burst) or accepts a valid/ready stream and writes it to consecutive addresses (write burst). It hides the memory's read latency and absorbs downstream backpressure without dropping or duplicating words.

## Interface
- DATA_W, 64, word width
- ADDR_W, 16, memory address width
- MEM_DEPTH, 49152, number of valid words; addresses 0..MEM_DEPTH-1
- FIFO_DEPTH, 2, read-side buffer entries
- clk  in  1  clock; one clock domain, everything on posedge
- rst  in  1  reset; synchronous, active-high
- start  in  1  command strobe, sampled only in IDLE
- dir  in  1  0 = read burst (mem→stream), 1 = write burst (stream→mem)
- base_addr  in  ADDR_W  first word address
- length  in  ADDR_W  number of words
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, command rejected (range)
- mem_address  out  ADDR_W  to memory address
- mem_data_out  out  DATA_W  to memory write data
- mem_we  out  1  to memory write enable
- mem_data_in  in  DATA_W  from memory read data (valid 1 cycle after address)
- rd_data  out  DATA_W, rd_valid  out  1, rd_ready  in  1  read stream
- wr_data  in  DATA_W, wr_valid  in  1, wr_ready  out  1  write stream

## Operation
- States: IDLE, RD, WR, DONE. IDLE→RD/WR on start with legal command; →DONE on illegal or length==0; RD/WR→DONE on completion; DONE→IDLE always.
- Legal: length>0 and base_addr+length ≤ MEM_DEPTH (computed at ADDR_W+1 bits, no wrap). Illegal: err and done pulse together in DONE, no memory access. length==0: done only.
- start while not IDLE ignored; command fields sampled only at accepted start.
- RD: issue addresses base_addr..base_addr+length-1 in order; issue only when FIFO occupancy + in-flight − pop-this-cycle < FIFO_DEPTH. Each issued word captured into FIFO the following cycle. rd_data/rd_valid driven from FIFO head; pop on rd_valid&rd_ready. Completion: last word popped.
- WR: wr_ready=1 while words remain; mem_we = wr_valid & wr_ready (combinational), mem_address = base_addr+count, mem_data_out = wr_data same cycle. Completion: last handshake.
- mem_we never asserts outside WR, and forced 0 while rst high.
- mem_address holds last driven value when idle/stalled (stray reads harmless).

## Timing
- Reset values: busy 0, done 0, err 0, mem_we 0, mem_address 0, mem_data_out 0, rd_valid 0, wr_ready 0, FIFO empty, state IDLE.
- busy 1 from cycle after accepted start until the cycle DONE is entered; 0 in DONE.
- Read latency: first rd_valid 2 cycles after first address issue (1 memory, 1 FIFO capture); first address issued cycle after start.
- Sustained 1 word/cycle with rd_ready held 1; with backpressure, no overflow, no loss, order preserved.
- Write: 1 word/cycle when wr_valid held 1.
- done asserted exactly 1 cycle, the cycle after completion; new start accepted the cycle after done.
- rst mid-transfer: all state cleared at that edge, in-flight read data discarded, no done/err.

## Structure
- Package mem_dma_pkg: DATA_W, ADDR_W, MEM_DEPTH constants, state enum (IDLE, RD, WR, DONE), dir enum.
- Sub-module stream_fifo: parametric FIFO_DEPTH synchronous FIFO with push/pop/occupancy; top holds FSM, counters, credit logic.

## Test plan
- Reset: hold rst 3 cycles → all outputs at reset values, mem_we 0 throughout.
- Read base 0x0010 len 4, rd_ready=1 → rd_data = mem[0x10..0x13] on 4 consecutive cycles, done once, busy low after.
- Read base 0x0100 len 8, rd_ready toggling 1,0,1,0… → exactly 8 words in order, no duplicates, FIFO never exceeds 2.
- Write base 0xBFFD len 3 with data 0xA..0xC, then read back → mem[49149..49151] = 0xA,0xB,0xC.
- Start base 0xBFFF len 2 → err and done same cycle, no mem_we; len 0 → done only.
- rst asserted after 2 of 6 read words → state IDLE, rd_valid 0 next cycle; new read len 1 completes correctly.
